// File: rtl/mux_n_reg.sv
// mux_n_reg: registered CHANNELS-to-1 mux with one blanking cycle on a channel switch and a valid/ready output stage.
// Optional auto-scan channel advance is compiled in when MUX_SCAN_EN is defined.
module mux_n_reg #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  localparam int SEL_W   = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] d,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      sel_ld,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      scan,
  output logic [WIDTH-1:0]          out,
  output logic [SEL_W-1:0]          out_ch,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      sel_err
);

  // state  | meaning
  // RUN    | transfers allowed, selection requests evaluated
  // SWITCH | one blanking cycle; cur takes the pending channel on exit
  typedef enum logic {RUN = 1'b0, SWITCH = 1'b1} state_t;

  localparam logic [SEL_W:0]   CH_LIM  = (SEL_W+1)'(CHANNELS);
  localparam logic [SEL_W-1:0] CH_LAST = SEL_W'(CHANNELS - 1);

  state_t           r_state, w_state_nxt;
  logic [SEL_W-1:0] r_cur, w_cur_nxt;
  logic [SEL_W-1:0] r_pend, w_pend_nxt;
  logic             r_sel_err, w_err_nxt;
  logic [WIDTH-1:0] r_out;
  logic [SEL_W-1:0] r_out_ch;
  logic             r_out_valid;
  logic [WIDTH-1:0] w_ch_data;
  logic             w_accept;
  logic             w_sel_ok;
  logic             w_scan_adv;

  assign in_ready  = (r_state == RUN) & (~r_out_valid | out_ready);
  assign w_accept  = in_valid & in_ready;
  assign w_sel_ok  = ({1'b0, sel} < CH_LIM);
  assign out       = r_out;
  assign out_ch    = r_out_ch;
  assign out_valid = r_out_valid;
  assign sel_err   = r_sel_err;

`ifdef MUX_SCAN_EN
  assign w_scan_adv = scan & w_accept;
`else
  logic w_unused_scan;
  assign w_unused_scan = scan;
  assign w_scan_adv    = 1'b0;
`endif

  always_comb begin
    w_ch_data = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (r_cur == SEL_W'(k)) w_ch_data = d[k*WIDTH +: WIDTH];
    end
  end

  // Any sel_ld in RUN suppresses a scan advance that cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_cur_nxt   = r_cur;
    w_pend_nxt  = r_pend;
    w_err_nxt   = 1'b0;
    case (r_state)
      RUN: begin
        if (sel_ld) begin
          if (!w_sel_ok) begin
            w_err_nxt = 1'b1;
          end else if (sel != r_cur) begin
            w_pend_nxt  = sel;
            w_state_nxt = SWITCH;
          end
        end else if (w_scan_adv) begin
          w_cur_nxt = (r_cur == CH_LAST) ? '0 : r_cur + SEL_W'(1);
        end
      end
      SWITCH: begin
        w_cur_nxt   = r_pend;
        w_state_nxt = RUN;
      end
      default: w_state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= RUN;
      r_cur     <= '0;
      r_pend    <= '0;
      r_sel_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cur     <= w_cur_nxt;
      r_pend    <= w_pend_nxt;
      r_sel_err <= w_err_nxt;
    end
  end

  // Output word keeps the tag of the channel that produced it, even across a switch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out       <= '0;
      r_out_ch    <= '0;
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out       <= w_ch_data;
      r_out_ch    <= r_cur;
      r_out_valid <= 1'b1;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_n_reg.sv
// Directed bench for mux_n_reg: 4-channel instance with an output scoreboard, plus a 3-channel instance for range errors.
module tb_mux_n_reg;

  typedef struct {
    logic [7:0] data;
    logic [1:0] ch;
  } sb_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;

  logic [31:0] d;
  logic [1:0]  sel;
  logic        sel_ld, in_valid, in_ready, scan, out_valid, out_ready, sel_err;
  logic [7:0]  out;
  logic [1:0]  out_ch;

  logic [23:0] d3;
  logic [1:0]  sel3;
  logic        sel_ld3, in_valid3, in_ready3, scan3, out_valid3, out_ready3, sel_err3;
  logic [7:0]  out3;
  logic [1:0]  out_ch3;

  sb_t sb[$];
  sb_t exp_e;
  int  n_assert = 0;
  int  n_fail   = 0;
  logic [1:0] scan_exp [5];

  always #5 clk = ~clk;

  mux_n_reg #(.WIDTH(8), .CHANNELS(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .d(d), .sel(sel), .sel_ld(sel_ld),
    .in_valid(in_valid), .in_ready(in_ready), .scan(scan),
    .out(out), .out_ch(out_ch), .out_valid(out_valid),
    .out_ready(out_ready), .sel_err(sel_err)
  );

  mux_n_reg #(.WIDTH(8), .CHANNELS(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .d(d3), .sel(sel3), .sel_ld(sel_ld3),
    .in_valid(in_valid3), .in_ready(in_ready3), .scan(scan3),
    .out(out3), .out_ch(out_ch3), .out_valid(out_valid3),
    .out_ready(out_ready3), .sel_err(sel_err3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] chan_data(input logic [1:0] ch);
    logic [31:0] dv;
    dv = d;
    return dv[ch*8 +: 8];
  endfunction

  // One cycle on the 4-channel instance; called and returns 1 time unit after a rising edge.
  task automatic tick(input logic v, input logic ordy, input logic sl, input logic [1:0] s,
                      input logic sc, input logic exp_rdy, input logic [1:0] exp_ch,
                      input string tag);
    in_valid  = v;
    out_ready = ordy;
    sel_ld    = sl;
    sel       = s;
    scan      = sc;
    #1;
    check({tag, ".in_ready"}, 32'(in_ready), 32'(exp_rdy));
    if (v && exp_rdy) sb.push_back('{data: chan_data(exp_ch), ch: exp_ch});
    @(posedge clk);
    #1;
    sel_ld = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      check("sb.word_pending", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        exp_e = sb.pop_front();
        check("sb.data", 32'(out), 32'(exp_e.data));
        check("sb.ch", 32'(out_ch), 32'(exp_e.ch));
      end
    end
  end

  initial begin
`ifdef MUX_SCAN_EN
    scan_exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
`else
    scan_exp = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`endif
    d = 32'h44332211; sel = '0; sel_ld = 0; in_valid = 0; scan = 0; out_ready = 0;
    d3 = 24'h332211; sel3 = '0; sel_ld3 = 0; in_valid3 = 0; scan3 = 0; out_ready3 = 1;

    rst_n = 1'b0;
    #1;
    check("rst.out", 32'(out), 32'h0);
    check("rst.out_ch", 32'(out_ch), 32'h0);
    check("rst.out_valid", 32'(out_valid), 32'h0);
    check("rst.sel_err", 32'(sel_err), 32'h0);
    check("rst.sel_err3", 32'(sel_err3), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    tick(1, 1, 0, 2'd0, 0, 1, 2'd0, "s1");
    check("s1.out", 32'(out), 32'h11);
    check("s1.out_ch", 32'(out_ch), 32'h0);
    tick(1, 1, 1, 2'd2, 0, 1, 2'd0, "s2_sel_and_accept");
    check("s2.out_ch_old", 32'(out_ch), 32'h0);
    tick(1, 1, 0, 2'd0, 0, 0, 2'd0, "s3_blank");
    check("s3.out_valid", 32'(out_valid), 32'h0);
    check("s3.out_held", 32'(out), 32'h11);
    tick(1, 1, 0, 2'd0, 0, 1, 2'd2, "s4");
    check("s4.out", 32'(out), 32'h33);
    check("s4.out_ch", 32'(out_ch), 32'h2);
    tick(1, 1, 1, 2'd2, 0, 1, 2'd2, "s5_same_sel");
    tick(1, 1, 0, 2'd0, 0, 1, 2'd2, "s6_no_blank");

    d = 32'h445A2211;
    for (int i = 0; i < 3; i++) begin
      tick(1, 0, 0, 2'd0, 0, 0, 2'd2, "stall");
      check("stall.out", 32'(out), 32'h33);
      check("stall.out_ch", 32'(out_ch), 32'h2);
      check("stall.out_valid", 32'(out_valid), 32'h1);
    end
    tick(1, 1, 0, 2'd0, 0, 1, 2'd2, "s10_resume");
    check("s10.out", 32'(out), 32'h5A);
    tick(0, 1, 0, 2'd0, 0, 1, 2'd2, "s11");
    tick(0, 0, 0, 2'd0, 0, 1, 2'd0, "s12");
    check("s12.out_valid", 32'(out_valid), 32'h0);

    tick(1, 1, 1, 2'd1, 0, 1, 2'd2, "s13");
    check("s13.out", 32'(out), 32'h5A);
    #2;
    in_valid = 0; out_ready = 0; rst_n = 1'b0;
    #1;
    check("midrst.out", 32'(out), 32'h0);
    check("midrst.out_ch", 32'(out_ch), 32'h0);
    check("midrst.out_valid", 32'(out_valid), 32'h0);
    check("midrst.in_ready", 32'(in_ready), 32'h1);
    sb.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick(1, 1, 0, 2'd0, 0, 1, 2'd0, "s14");
    check("s14.out", 32'(out), 32'h11);
    check("s14.out_ch", 32'(out_ch), 32'h0);
    tick(0, 1, 0, 2'd0, 0, 1, 2'd0, "s15");

    for (int i = 0; i < 5; i++) begin
      tick(1, 1, 0, 2'd0, 1, 1, scan_exp[i], "scan");
      check("scan.out_ch", 32'(out_ch), 32'(scan_exp[i]));
    end
    tick(0, 1, 0, 2'd0, 0, 1, 2'd0, "drain");

    sel3 = 2'd3; sel_ld3 = 1;
    @(posedge clk);
    #1 sel_ld3 = 0;
    check("d3.err_pulse", 32'(sel_err3), 32'h1);
    check("d3.no_switch", 32'(in_ready3), 32'h1);
    @(posedge clk);
    #1;
    check("d3.err_one_cycle", 32'(sel_err3), 32'h0);
    in_valid3 = 1;
    @(posedge clk);
    #1 in_valid3 = 0;
    check("d3.cur_kept_out", 32'(out3), 32'h11);
    check("d3.cur_kept_ch", 32'(out_ch3), 32'h0);
    sel3 = 2'd1; sel_ld3 = 1;
    @(posedge clk);
    #1 sel3 = 2'd3;
    #1;
    check("d3.switch_blank", 32'(in_ready3), 32'h0);
    @(posedge clk);
    #1 sel_ld3 = 0;
    check("d3.no_err_in_switch", 32'(sel_err3), 32'h0);
    in_valid3 = 1;
    #1;
    check("d3.run_again", 32'(in_ready3), 32'h1);
    @(posedge clk);
    #1 in_valid3 = 0;
    check("d3.new_out", 32'(out3), 32'h22);
    check("d3.new_ch", 32'(out_ch3), 32'h1);

    check("sb.empty", 32'(sb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_n_reg.md
MUX_N_REG -- requirements
Module: mux_n_reg

Interface
REQ-001 Parameter WIDTH, default 8: bit width of each data channel; legal range 1..32.
REQ-002 Parameter CHANNELS, default 4: number of input channels; legal range 2..16. SEL_W = ceil(log2(CHANNELS)) is a derived local constant.
REQ-003 Port list, in order:
- clk, input, 1: rising-edge clock; the single clock of the block.
- rst_n, input, 1: asynchronous active-low reset.
- d, input, CHANNELS*WIDTH: flattened channel data; channel k occupies bits [k*WIDTH +: WIDTH].
- sel, input, SEL_W: requested channel.
- sel_ld, input, 1: pulse that requests a channel change to sel.
- in_valid, input, 1: the selected channel's data is valid this cycle.
- in_ready, output, 1: the block accepts data this cycle.
- scan, input, 1: auto-scan request; honoured only with MUX_SCAN_EN (REQ-020).
- out, output, WIDTH: registered output data.
- out_ch, output, SEL_W: channel index that produced out.
- out_valid, output, 1: out holds unconsumed data.
- out_ready, input, 1: the downstream side consumes out this cycle.
- sel_err, output, 1: one-cycle pulse flagging a rejected selection.

Function
REQ-004 The block shall hold an internal current-channel register cur, width SEL_W.
REQ-005 The block shall implement two states: RUN and SWITCH.
REQ-006 In RUN, sel_ld=1 with sel<CHANNELS and sel!=cur shall latch sel as pending and move to SWITCH at the next edge.
REQ-007 In RUN, sel_ld=1 with sel==cur shall cause no state change and no blanking.
REQ-008 sel_ld=1 with sel>=CHANNELS shall be ignored; sel_err shall be 1 for exactly the following cycle.
REQ-009 SWITCH shall last exactly one cycle; at its exit edge cur takes the pending value and the state returns to RUN.
REQ-010 sel_ld asserted while in SWITCH shall be ignored, with no error pulse.
REQ-011 in_ready = (state==RUN) AND (NOT out_valid OR out_ready); combinational, with no dependency on in_valid.
REQ-012 Accept = in_valid AND in_ready. On accept, at the next edge: out <= d channel cur, out_ch <= cur, out_valid <= 1.
REQ-013 out_valid AND out_ready with no accept shall clear out_valid at the next edge; out and out_ch shall hold their values.
REQ-014 Simultaneous consume and accept shall give back-to-back transfers at full throughput, with out_valid staying 1.
REQ-015 While out_valid=1 and out_ready=0, out and out_ch shall remain stable.
REQ-016 Latency from accept to out_valid shall be 1 cycle.
REQ-017 A word already held in out during a switch shall be kept, still tagged with its original out_ch.
REQ-018 Data shall pass through unmodified: no arithmetic or width conversion.

Reset
REQ-019 rst_n=0 shall immediately, without waiting for clk, force:
- out=0, out_ch=0, out_valid=0, sel_err=0;
- cur=0, state=RUN, pending selection=0.

Reset asserted mid-SWITCH or mid-transfer shall abandon the operation. After release, the first accept shall use channel 0.

Configuration
REQ-020 Macro MUX_SCAN_EN, when defined, compiles in auto-scan:
- In RUN with scan=1, each accept advances cur to cur+1 at the same edge, wrapping from CHANNELS-1 to 0.
- A scan advance causes no SWITCH blanking.
- sel_ld takes priority over a scan advance in the same cycle.

When MUX_SCAN_EN is undefined, the scan port shall exist and be ignored, and cur shall change only through REQ-006 and REQ-009.

Verification
REQ-021 Reset, then WIDTH=8 with d ch0=0x11, ch1=0x22, in_valid=1, out_ready=1 -> out=0x11 and out_ch=0 one cycle after the first accept.
REQ-022 sel=2, sel_ld pulse -> in_ready=0 for exactly one cycle, then out=ch2 data with out_ch=2; a repeat of sel=2, sel_ld -> no blanking cycle.
REQ-023 out_ready=0 for 3 cycles with in_valid=1 -> out and out_valid held, in_ready=0; out_ready=1 -> data resumes with no loss or duplication.
REQ-024 CHANNELS=3, sel=3, sel_ld -> sel_err high for one cycle and cur unchanged; rst_n pulsed low during SWITCH -> all outputs 0 at once and cur=0.
REQ-025 With MUX_SCAN_EN, CHANNELS=4, scan=1, 5 accepts -> out_ch sequence 0,1,2,3,0; without the macro, the same stimulus -> all 0.
REQ-026 sel_ld and accept in the same cycle -> the accepted word is tagged with the old cur, the next cycle is blanked, then the new channel is used.
